// File: rtl/text_tx_arbiter.sv
// rtl/text_tx_arbiter.sv - round-robin text frame arbiter feeding the MinOS transmitter
module text_tx_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int TEXT_BYTES = 32
) (
  input  logic                            CLK,
  input  logic                            RST_N,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*TEXT_BYTES*8-1:0] req_text_bytes,
  input  logic [NUM_REQ*8-1:0]            req_text_size,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [TEXT_BYTES*8-1:0]         tx_text_bytes,
  output logic [7:0]                      tx_text_size,
  output logic                            tx_text_send,
  input  logic                            tx_text_busy,
  output logic [7:0]                      active_index,
  output logic [7:0]                      drop_count,
  output logic                            tx_timeout
);

  localparam int FW = TEXT_BYTES * 8;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE} state_t;

  state_t        state_q;
  logic [7:0]    last_grant_q;
  logic [7:0]    active_q;
  logic [7:0]    drop_q;
  logic [FW-1:0] bytes_q;
  logic [7:0]    size_q;
  logic          send_q;
  logic          timeout_q;
  logic [3:0]    wait_cnt_q;

  logic          grant_found;
  logic [7:0]    grant_idx;
  logic [FW-1:0] sel_bytes;
  logic [7:0]    sel_size;
  logic [7:0]    clip_size;
  logic          accept;

  // Round-robin search beginning just after the previous grant.
  always_comb begin
    int idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant_q) + k) % NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!grant_found && (i == idx) && req_valid[i]) begin
          grant_found = 1'b1;
          grant_idx   = 8'(i);
        end
      end
    end
  end

  always_comb begin
    sel_bytes = '0;
    sel_size  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == 8'(i)) begin
        sel_bytes = req_text_bytes[i*FW +: FW];
        sel_size  = req_text_size[i*8 +: 8];
      end
    end
    clip_size = (int'(sel_size) > TEXT_BYTES) ? 8'(TEXT_BYTES) : sel_size;
  end

  // Reset input gates the grant so req_ready drops the moment RST_N falls.
  assign accept = RST_N && (state_q == IDLE) && !tx_text_busy && grant_found;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = accept && (grant_idx == 8'(i));
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      last_grant_q <= 8'(NUM_REQ - 1);
      active_q     <= '0;
      drop_q       <= '0;
      bytes_q      <= '0;
      size_q       <= '0;
      send_q       <= 1'b0;
      timeout_q    <= 1'b0;
      wait_cnt_q   <= '0;
    end else begin
      send_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            active_q     <= grant_idx;
            last_grant_q <= grant_idx;
            if (sel_size == 8'd0) begin
              if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
            end else begin
              bytes_q <= sel_bytes;
              size_q  <= clip_size;
              send_q  <= 1'b1;
              state_q <= SEND;
            end
          end
        end
        SEND: begin
          wait_cnt_q <= '0;
          state_q    <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (tx_text_busy) begin
            state_q <= WAIT_DONE;
          end else if (wait_cnt_q == 4'hF) begin
            timeout_q <= 1'b1;
            state_q   <= IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 4'd1;
          end
        end
        WAIT_DONE: begin
          if (!tx_text_busy) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_text_bytes = bytes_q;
  assign tx_text_size  = size_q;
  assign tx_text_send  = send_q;
  assign active_index  = active_q;
  assign drop_count    = drop_q;
  assign tx_timeout    = timeout_q;

endmodule

// File: doc/text_tx_arbiter.md
TEXT_TX_ARBITER -- requirements
Module: text_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3: number of text requesters, legal range 2..8.
REQ-002 Parameter TEXT_BYTES, default 32: bytes per text frame, matching the MinOS text channel.
REQ-003 The block SHALL have port CLK, input, 1: single system clock, all state on rising edge.
REQ-004 The block SHALL have port RST_N, input, 1: asynchronous, active-low reset.
REQ-005 The block SHALL have port req_valid, input, NUM_REQ: bit i high = requester i holds a frame.
REQ-006 The block SHALL have port req_text_bytes, input, NUM_REQ*TEXT_BYTES*8: requester i frame at slice [i*TEXT_BYTES*8 +: TEXT_BYTES*8].
REQ-007 The block SHALL have port req_text_size, input, NUM_REQ*8: requester i byte count at slice [i*8 +: 8].
REQ-008 The block SHALL have port req_ready, output, NUM_REQ: one-hot accept; transfer when req_valid[i] and req_ready[i] are both high at a rising edge.
REQ-009 The block SHALL have port tx_text_bytes, output, TEXT_BYTES*8: frame to the MinOS transmitter.
REQ-010 The block SHALL have port tx_text_size, output, 8: byte count to the MinOS transmitter.
REQ-011 The block SHALL have port tx_text_send, output, 1: one-cycle start strobe to MinOS.
REQ-012 The block SHALL have port tx_text_busy, input, 1: MinOS transmit in progress.
REQ-013 The block SHALL have port active_index, output, 8: index of the last accepted requester.
REQ-014 The block SHALL have port drop_count, output, 8: count of discarded zero-size frames, saturating.
REQ-015 The block SHALL have port tx_timeout, output, 1: sticky flag, MinOS failed to go busy.

Function
REQ-016 FSM states SHALL be IDLE, SEND, WAIT_BUSY, WAIT_DONE.
REQ-017 IDLE: with tx_text_busy low and any req_valid high, the block SHALL assert req_ready combinationally for exactly one requester; all other req_ready bits SHALL be low.
REQ-018 Selection SHALL be round-robin: search starts at last_grant+1 and wraps modulo NUM_REQ.
REQ-019 In states other than IDLE, or while tx_text_busy is high, all req_ready bits SHALL be low.
REQ-020 On accept, the block SHALL register the frame into tx_text_bytes and set active_index=i and last_grant=i.
REQ-021 On accept, the block SHALL register tx_text_size as min(size, TEXT_BYTES).
REQ-022 A zero-size accept SHALL stay in IDLE, leave the tx_* outputs unchanged, and increment drop_count, saturating at 255.
REQ-023 A nonzero accept SHALL enter SEND on the next cycle; tx_text_send SHALL be high for exactly that one cycle, 1 cycle after accept.
REQ-024 SEND SHALL advance unconditionally to WAIT_BUSY.
REQ-025 WAIT_BUSY SHALL run a 4-bit counter.
REQ-026 In WAIT_BUSY, tx_text_busy high SHALL move the FSM to WAIT_DONE.
REQ-027 In WAIT_BUSY, 16 cycles without busy SHALL set tx_timeout and return the FSM to IDLE.
REQ-028 WAIT_DONE SHALL return to IDLE on the first cycle tx_text_busy is low.
REQ-029 tx_text_bytes and tx_text_size SHALL stay stable from accept until the next nonzero accept.
REQ-030 The block SHALL ignore changes to req_* inputs outside the accept edge.
REQ-031 Simultaneous valid requesters SHALL be served one frame each in rotation, with no requester starved beyond NUM_REQ-1 frames.
REQ-032 A requester deasserting req_valid before it is granted SHALL be skipped without penalty.

Reset
REQ-033 RST_N low SHALL immediately force state IDLE and zero req_ready, tx_text_bytes, tx_text_size, tx_text_send, active_index, drop_count and tx_timeout.
REQ-034 RST_N low SHALL force last_grant=NUM_REQ-1, so requester 0 has first priority.
REQ-035 Reset asserted mid-frame SHALL abandon the frame with no further send strobe.
REQ-036 Reset SHALL be the only clear for tx_timeout and drop_count.

Verification
REQ-037 Scenario: reset; req_valid=001, size=5, busy pulses 2 cycles after send, lasts 10 cycles -> req_ready=001 one cycle; send high on the next cycle; tx_text_size=5; active_index=0.
REQ-038 Scenario: req_valid=111 held, busy modelled -> accepts in order 0,1,2,0; exactly one send per frame.
REQ-039 Scenario: size=0 on requester 1 -> accepted, no send, drop_count=1; 300 such frames -> drop_count=255.
REQ-040 Scenario: size=40 -> tx_text_size=32.
REQ-041 Scenario: busy never asserts after send -> FSM in IDLE 17 cycles after send, tx_timeout=1, next request still served.
REQ-042 Scenario: RST_N low in WAIT_DONE -> all outputs zero; after release, requester 0 wins against requester 2.
